// File: rtl/rld_rr_burst_arbiter.sv
// rld_rr_burst_arbiter
//   Round-robin read-burst arbiter for the RLDRAM output side. A queue is
//   granted for up to BURST_LEN issued reads. Each queue is limited to
//   MAX_OUTSTANDING reads in flight. Returned read words are demultiplexed
//   onto registered per-queue lanes.
//
//   Optional build macro RLD_ARB_STRICT_Q0_EN: when defined, queue 0 wins
//   every IDLE arbitration in which it is eligible. Queues 1..N-1 keep
//   round-robin order among themselves. A running burst is never pre-empted.
//
// Ports
//   memclk, reset      : clock and synchronous active-high reset
//   mem_queue_empty    : per-queue "no data in RLDRAM"
//   full               : per-queue downstream FIFO almost-full
//   q_read_select      : scheduler accepts a read this cycle
//   burst_inc          : one-hot read-issue strobe (combinational)
//   queue_id           : currently granted queue (registered)
//   grant_valid        : arbiter is in BURST
//   din_valid, din,
//   din_queue_id       : returned read word and the queue it belongs to
//   dout, dout_valid   : per-queue registered return lanes, one-hot valid
//   protocol_err       : sticky flag for underflowing returns or bad queue ids
module rld_rr_burst_arbiter #(
   parameter int NUM_QUEUES      = 4,
   parameter int QUEUE_ID_WIDTH  = 2,
   parameter int DATA_WIDTH      = 278,
   parameter int BURST_LEN       = 4,
   parameter int MAX_OUTSTANDING = 8,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                             memclk,
   input  logic                             reset,
   input  logic [NUM_QUEUES-1:0]            mem_queue_empty,
   input  logic [NUM_QUEUES-1:0]            full,
   input  logic                             q_read_select,
   output logic [NUM_QUEUES-1:0]            burst_inc,
   output logic [QUEUE_ID_WIDTH-1:0]        queue_id,
   output logic                             grant_valid,
   input  logic                             din_valid,
   input  logic [DATA_WIDTH-1:0]            din,
   input  logic [QUEUE_ID_WIDTH-1:0]        din_queue_id,
   output logic [NUM_QUEUES*DATA_WIDTH-1:0] dout,
   output logic [NUM_QUEUES-1:0]            dout_valid,
   output logic                             protocol_err
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0]         BEAT_LAST = BEAT_W'(BURST_LEN - 1);
   localparam logic [CNT_WIDTH-1:0]      CNT_MAX   = CNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [QUEUE_ID_WIDTH-1:0] ID_LAST   = QUEUE_ID_WIDTH'(NUM_QUEUES - 1);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t                    state_q, state_d;
   logic [QUEUE_ID_WIDTH-1:0] queue_id_q, last_id_q, pick_id;
   logic                      pick_found;
   logic [BEAT_W-1:0]         beat_q;
   logic [CNT_WIDTH-1:0]      outstanding_q [NUM_QUEUES];
   logic [NUM_QUEUES-1:0]     eligible;
   logic [NUM_QUEUES-1:0]     ret_hit;
   logic [NUM_QUEUES-1:0]     underflow;
   logic                      issue;
   logic                      din_in_range;

   // Returns {found, id}: first eligible queue after 'last', wrapping at NUM_QUEUES.
   function automatic logic [QUEUE_ID_WIDTH:0] rr_pick(
      input logic [NUM_QUEUES-1:0]     elig,
      input logic [QUEUE_ID_WIDTH-1:0] last
   );
      logic [QUEUE_ID_WIDTH:0]   r;
      logic [QUEUE_ID_WIDTH-1:0] cand;
      r    = '0;
      cand = last;
      for (int k = 0; k < NUM_QUEUES; k++) begin
         cand = (cand == ID_LAST) ? '0 : cand + QUEUE_ID_WIDTH'(1);
         if (!r[QUEUE_ID_WIDTH] && elig[cand]) r = {1'b1, cand};
      end
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_QUEUES; i++)
         eligible[i] = ~mem_queue_empty[i] & ~full[i] & (outstanding_q[i] < CNT_MAX);
   end

   always_comb begin
`ifdef RLD_ARB_STRICT_Q0_EN
      if (eligible[0]) {pick_found, pick_id} = {1'b1, {QUEUE_ID_WIDTH{1'b0}}};
      else             {pick_found, pick_id} = rr_pick(eligible, last_id_q);
`else
      {pick_found, pick_id} = rr_pick(eligible, last_id_q);
`endif
   end

   // Queue ids beyond NUM_QUEUES only exist for non-power-of-two configurations.
   assign din_in_range = int'(din_queue_id) < NUM_QUEUES;

   always_comb begin
      for (int i = 0; i < NUM_QUEUES; i++)
         ret_hit[i] = din_valid & din_in_range & (din_queue_id == QUEUE_ID_WIDTH'(i));
   end

   always_comb begin
      state_d   = state_q;
      issue     = 1'b0;
      burst_inc = '0;
      if (state_q == BURST) begin
         issue = q_read_select & eligible[queue_id_q] & ~reset;
         if (!eligible[queue_id_q] || (issue && beat_q == BEAT_LAST)) state_d = IDLE;
      end else if (pick_found) begin
         state_d = BURST;
      end
      if (issue) burst_inc[queue_id_q] = 1'b1;
   end

   always_ff @(posedge memclk) begin
      if (reset) begin
         state_q    <= IDLE;
         queue_id_q <= '0;
         last_id_q  <= ID_LAST;
         beat_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && pick_found) begin
            queue_id_q <= pick_id;
            beat_q     <= '0;
         end
         if (issue) beat_q <= beat_q + BEAT_W'(1);
         if (state_q == BURST && state_d == IDLE) last_id_q <= queue_id_q;
      end
   end

   // Issue and return on the same queue cancel; a lone return at zero is an error.
   always_comb begin
      for (int i = 0; i < NUM_QUEUES; i++)
         underflow[i] = ret_hit[i] & ~burst_inc[i] & (outstanding_q[i] == '0);
   end

   always_ff @(posedge memclk) begin
      if (reset) begin
         for (int i = 0; i < NUM_QUEUES; i++) outstanding_q[i] <= '0;
         protocol_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_QUEUES; i++) begin
            if (burst_inc[i] && !ret_hit[i])
               outstanding_q[i] <= outstanding_q[i] + CNT_WIDTH'(1);
            else if (ret_hit[i] && !burst_inc[i] && outstanding_q[i] != '0)
               outstanding_q[i] <= outstanding_q[i] - CNT_WIDTH'(1);
         end
         if ((|underflow) || (din_valid && !din_in_range)) protocol_err <= 1'b1;
      end
   end

   // Return path: one register stage, din -> lane_p1
   logic [NUM_QUEUES*DATA_WIDTH-1:0] dout_p1;
   logic [NUM_QUEUES-1:0]            vld_p1;

   always_ff @(posedge memclk) begin
      if (reset) begin
         dout_p1 <= '0;
         vld_p1  <= '0;
      end else begin
         vld_p1 <= ret_hit;
         for (int i = 0; i < NUM_QUEUES; i++)
            dout_p1[i*DATA_WIDTH +: DATA_WIDTH] <= ret_hit[i] ? din : '0;
      end
   end

   assign dout        = dout_p1;
   assign dout_valid  = vld_p1;
   assign queue_id    = queue_id_q;
   assign grant_valid = (state_q == BURST);

endmodule

// File: tb/tb_rld_rr_burst_arbiter.sv
// Testbench for rld_rr_burst_arbiter (default parameters: 4 queues,
// BURST_LEN 4, MAX_OUTSTANDING 8). Honours RLD_ARB_STRICT_Q0_EN when defined.
module tb_rld_rr_burst_arbiter;
   localparam int N  = 4;
   localparam int DW = 278;

   logic            memclk;
   logic            reset;
   logic [N-1:0]    mem_queue_empty;
   logic [N-1:0]    full;
   logic            q_read_select;
   logic [N-1:0]    burst_inc;
   logic [1:0]      queue_id;
   logic            grant_valid;
   logic            din_valid;
   logic [DW-1:0]   din;
   logic [1:0]      din_queue_id;
   logic [N*DW-1:0] dout;
   logic [N-1:0]    dout_valid;
   logic            protocol_err;

   rld_rr_burst_arbiter dut (
      .memclk(memclk), .reset(reset), .mem_queue_empty(mem_queue_empty), .full(full),
      .q_read_select(q_read_select), .burst_inc(burst_inc), .queue_id(queue_id),
      .grant_valid(grant_valid), .din_valid(din_valid), .din(din),
      .din_queue_id(din_queue_id), .dout(dout), .dout_valid(dout_valid),
      .protocol_err(protocol_err)
   );

   initial memclk = 1'b0;
   always #5 memclk = ~memclk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc_cnt = 0;
   always @(posedge memclk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      int            due;
      logic [N-1:0]  vmask;
      int            id;
      logic [DW-1:0] data;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      logic          dv;
      logic [1:0]    id;
      logic [DW-1:0] d;
      logic [N-1:0]  exp_v;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_lane(input int l, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL dout_lane%0d: got %0h expected %0h", l, act, exp);
      end
   endtask

   // Return-path scoreboard: compare the entry due in this cycle, else expect silence.
   always @(negedge memclk) begin
      sb_t e;
      if (sb.size() > 0 && sb[0].due < cyc_cnt) begin
         n_cmp++; n_fail++;
         $display("FAIL sb_missed: expected return due cycle %0d not seen", sb[0].due);
         e = sb.pop_front();
      end
      if (sb.size() > 0 && sb[0].due == cyc_cnt) begin
         e = sb.pop_front();
         chk("dout_valid", 32'(dout_valid), 32'(e.vmask));
         for (int l = 0; l < N; l++)
            chk_lane(l, dout[l*DW +: DW], (l == e.id) ? e.data : '0);
      end else begin
         chk("dout_idle", 32'(dout_valid), 32'd0);
      end
   end

   task automatic next_cycle();
      @(posedge memclk);
      #1;
   endtask

   task automatic drive_ret(input logic [1:0] id, input logic [DW-1:0] d, input logic [N-1:0] ev);
      din_valid    = 1'b1;
      din_queue_id = id;
      din          = d;
      sb.push_back('{cyc_cnt + 1, ev, int'(id), d});
   endtask

   task automatic idle_inputs();
      mem_queue_empty = '1;
      full            = '0;
      q_read_select   = 1'b0;
      din_valid       = 1'b0;
      din_queue_id    = '0;
      din             = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_burst_inc", 32'(burst_inc), 32'd0);
      idle_inputs();
      next_cycle();
      chk("rst_grant_valid", 32'(grant_valid), 32'd0);
      chk("rst_queue_id", 32'(queue_id), 32'd0);
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_dout_zero", 32'(dout == '0), 32'd1);
      chk("rst_protocol_err", 32'(protocol_err), 32'd0);
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int issues;
      int exp_q;

      tbl[0] = '{1'b1, 2'd3, DW'(12'hABC), 4'b1000};
      tbl[1] = '{1'b1, 2'd0, DW'(12'h111), 4'b0001};
      tbl[2] = '{1'b1, 2'd1, DW'(12'h222), 4'b0010};
      tbl[3] = '{1'b0, 2'd2, DW'(12'h333), 4'b0000};
      tbl[4] = '{1'b1, 2'd2, {22'h3AAAAA, {8{32'hDEADBEEF}}}, 4'b0100};
      tbl[5] = '{1'b1, 2'd1, {1'b1, 277'h0}, 4'b0010};

      reset = 1'b1;
      idle_inputs();
      next_cycle();

      // Reset, all queues empty: quiet for 20 cycles.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         #1;
         chk("t1_burst_inc", 32'(burst_inc), 32'd0);
         chk("t1_grant_valid", 32'(grant_valid), 32'd0);
         chk("t1_protocol_err", 32'(protocol_err), 32'd0);
         next_cycle();
      end

      // All eligible: grants 0,1,2,3,0, four strobes each, one IDLE between.
      mem_queue_empty = '0;
      q_read_select   = 1'b1;
      for (int c = 0; c < 25; c++) begin
         int q;
         logic g;
         g = (c % 5) != 0;
         q = (c / 5) % 4;
         #1;
         chk("t2_grant_valid", 32'(grant_valid), 32'(g));
         chk("t2_burst_inc", 32'(burst_inc), g ? (32'd1 << q) : 32'd0);
         if (g) chk("t2_queue_id", 32'(queue_id), 32'(q));
         next_cycle();
      end
      #1;
      chk("t2_idle_gap", 32'(grant_valid), 32'd0);
      next_cycle();
      #1;
      chk("t2_grant_q1", 32'(queue_id), 32'd1);
      chk("t2_inc_q1", 32'(burst_inc), 32'b0010);
      // Reset mid-burst: strobe gated immediately, FSM idle next edge.
      do_reset();

      // Queue 2 only: 8 credits, then stall; one return buys exactly one more.
      mem_queue_empty = 4'b1011;
      q_read_select   = 1'b1;
      issues = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (burst_inc == 4'b0100) issues++;
         else chk("t3_stray_inc", 32'(burst_inc), 32'd0);
         next_cycle();
      end
      chk("t3_issues_to_limit", 32'(issues), 32'd8);
      drive_ret(2'd2, DW'(12'h5A5), 4'b0100);
      #1;
      chk("t3_stalled_grant", 32'(grant_valid), 32'd0);
      next_cycle();
      din_valid = 1'b0;
      issues = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (burst_inc == 4'b0100) issues++;
         next_cycle();
      end
      chk("t3_issues_after_return", 32'(issues), 32'd1);
      chk("t3_protocol_err", 32'(protocol_err), 32'd0);
      do_reset();

      // Queue 1 granted; full[1] after two issues -> exit, then queue 2.
      mem_queue_empty = 4'b1001;
      q_read_select   = 1'b1;
      #1; chk("t4_c0_gv", 32'(grant_valid), 32'd0); next_cycle();
      #1; chk("t4_c1_qid", 32'(queue_id), 32'd1); chk("t4_c1_inc", 32'(burst_inc), 32'b0010); next_cycle();
      #1; chk("t4_c2_inc", 32'(burst_inc), 32'b0010); next_cycle();
      full = 4'b0010;
      #1; chk("t4_c3_gv", 32'(grant_valid), 32'd1); chk("t4_c3_inc", 32'(burst_inc), 32'd0); next_cycle();
      #1; chk("t4_c4_gv", 32'(grant_valid), 32'd0); next_cycle();
      #1; chk("t4_c5_qid", 32'(queue_id), 32'd2); chk("t4_c5_inc", 32'(burst_inc), 32'b0100); next_cycle();
      do_reset();

      // Return with zero outstanding -> sticky protocol_err.
      drive_ret(2'd0, DW'(12'h077), 4'b0001);
      next_cycle();
      din_valid = 1'b0;
      #1; chk("t6_err_set", 32'(protocol_err), 32'd1);
      repeat (5) next_cycle();
      #1; chk("t6_err_sticky", 32'(protocol_err), 32'd1);

      // Return-path vectors, back-to-back.
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].dv) drive_ret(tbl[i].id, tbl[i].d, tbl[i].exp_v);
         else din_valid = 1'b0;
         next_cycle();
      end
      din_valid = 1'b0;
      next_cycle();
      next_cycle();
      chk("t5_err_still", 32'(protocol_err), 32'd1);
      do_reset();

      // Simultaneous issue and return on queue 0 leaves the count unchanged:
      // 8 credits + 1 cancelled issue = 9 issues before the stall.
      mem_queue_empty = 4'b1110;
      q_read_select   = 1'b1;
      issues = 0;
      for (int c = 0; c < 25; c++) begin
         if (c == 6) drive_ret(2'd0, DW'(12'hC0C), 4'b0001);
         #1;
         if (c == 6) chk("t6_issue_with_return", 32'(burst_inc), 32'b0001);
         if (burst_inc == 4'b0001) issues++;
         next_cycle();
         din_valid = 1'b0;
      end
      chk("t6_issues_total", 32'(issues), 32'd9);
      chk("t6_no_err", 32'(protocol_err), 32'd0);
      do_reset();

      // Queues 0 and 3 eligible, last_id=3 after reset.
`ifdef RLD_ARB_STRICT_Q0_EN
      exp_q = 0;
`else
      exp_q = 3;
`endif
      mem_queue_empty = 4'b0110;
      q_read_select   = 1'b1;
      next_cycle();
      #1; chk("t7_first_grant", 32'(queue_id), 32'd0); chk("t7_first_gv", 32'(grant_valid), 32'd1);
      repeat (5) next_cycle();
      #1; chk("t7_second_grant", 32'(queue_id), 32'(exp_q)); chk("t7_second_gv", 32'(grant_valid), 32'd1);
      do_reset();

      next_cycle();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/rld_rr_burst_arbiter.md
Name: rld_rr_burst_arbiter

Overview:
Parametrised successor to the RLDRAM output-side FIFO arbiter. It grants read bursts round-robin across NUM_QUEUES memory-backed queues. A granted queue is held for up to BURST_LEN issued reads, and each queue has a per-queue outstanding-read credit limit. Returned read data is demultiplexed and registered onto per-queue output lanes. It sits between the RLDRAM read scheduler and the per-port output FIFOs, in the memclk domain.

Parameters:
NUM_QUEUES, 4, number of queues/ports (2..16)
QUEUE_ID_WIDTH, 2, width of queue ids; must equal clog2(NUM_QUEUES)
DATA_WIDTH, 278, bits per returned read word (data+tkeep+ctrl)
BURST_LEN, 4, max reads issued per grant (1..256)
MAX_OUTSTANDING, 8, max reads in flight per queue (1..255)
CNT_WIDTH, 8, width of per-queue outstanding counter; must be able to hold MAX_OUTSTANDING

Ports:
memclk  in  1  clock
reset  in  1  synchronous, active-high
mem_queue_empty  in  NUM_QUEUES  per-queue "no data in RLDRAM"
full  in  NUM_QUEUES  per-queue downstream FIFO almost-full
q_read_select  in  1  memory scheduler accepts a read this cycle
burst_inc  out  NUM_QUEUES  one-hot read-issue strobe (combinational)
queue_id  out  QUEUE_ID_WIDTH  currently granted queue (registered)
grant_valid  out  1  arbiter is in BURST state
din_valid  in  1  returned read word valid
din  in  DATA_WIDTH  returned read word
din_queue_id  in  QUEUE_ID_WIDTH  queue the returned word belongs to
dout  out  NUM_QUEUES*DATA_WIDTH  per-queue lanes; lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
dout_valid  out  NUM_QUEUES  one-hot lane valid (registered)
protocol_err  out  1  sticky error flag

Behaviour:
- Reset values: queue_id=0, grant_valid=0, dout=0, dout_valid=0, protocol_err=0; all outstanding counters=0; beat counter=0; last_id=NUM_QUEUES-1, so the first search starts at queue 0. burst_inc=0 while reset is high.
- eligible[i] = ~mem_queue_empty[i] & ~full[i] & (outstanding[i] < MAX_OUTSTANDING).
- FSM has two states: IDLE and BURST.
- IDLE: search eligible starting at (last_id+1) mod NUM_QUEUES with wrap-around; the first hit wins. On a hit: queue_id<=winner, beat<=0, go to BURST. No hit: stay in IDLE.
- BURST (grant_valid=1): issue = q_read_select & eligible[queue_id].
  - burst_inc[queue_id]=issue in the same cycle (zero latency).
  - On issue: beat<=beat+1.
- BURST exit: on issue with beat==BURST_LEN-1, or any cycle where eligible[queue_id]=0. Either way: last_id<=queue_id, go to IDLE.
- Minimum one IDLE cycle between grants. With all queues eligible, a full grant cycle is therefore BURST_LEN+1 cycles per queue.
- outstanding[i] update rules:
  - +1 on burst_inc[i].
  - -1 on din_valid with din_queue_id==i.
  - Both in the same cycle: unchanged.
  - Decrement at 0: saturate at 0 and set protocol_err.
  - Counter never exceeds MAX_OUTSTANDING, by construction of eligible.
- Return path has one-cycle latency: dout_valid<=onehot(din_queue_id) & {NUM_QUEUES{din_valid}}. The dout lane for din_queue_id <= din; all other lanes <= 0.
- din_queue_id >= NUM_QUEUES (non-power-of-two configs): word dropped, protocol_err set.
- protocol_err is sticky until reset.
- Reset asserted mid-burst: FSM to IDLE and all counters cleared next edge. In-flight returns arriving after reset are handled as zero-outstanding decrements (flagged).

Optional Feature:
Macro RLD_ARB_STRICT_Q0_EN.
- Defined: queue 0 is strict priority. In IDLE, if eligible[0], queue 0 wins regardless of last_id. Queues 1..N-1 round-robin among themselves using last_id. A burst already granted to another queue is not pre-empted.
- Undefined: pure round-robin as above.

Test Plan:
1. Reset, all queues empty -> burst_inc=0, grant_valid=0, dout_valid=0 for 20 cycles; protocol_err=0.
2. N=4, BURST_LEN=4, all queues eligible, q_read_select=1 -> grants 0,1,2,3,0; exactly 4 burst_inc pulses per grant, one IDLE cycle between grants.
3. Queue 2 only, MAX_OUTSTANDING=8, no returns -> 8 issues, then exit to IDLE and no regrant. Inject one din_valid for queue 2 -> regrant, exactly 1 further issue.
4. Queue 1 granted; full[1] rises after 2 issues -> exit after 2, next grant goes to queue 2 (if eligible), not queue 1.
5. din_valid=1, din_queue_id=3, din=0xABC -> next cycle dout_valid=4'b1000, lane 3=0xABC, lanes 0-2=0. Back-to-back returns to queues 0 and 1 -> consecutive one-hot valids.
6. din_valid for queue 0 with outstanding[0]=0 -> protocol_err=1 and stays 1. Simultaneous issue and return on the same queue -> counter unchanged. With RLD_ARB_STRICT_Q0_EN and queues 0 and 3 eligible, last_id=3 -> queue 0 granted every IDLE.
